// File: rtl/display_hdmi_data_pack_pkg.sv
// Shared constants for the HDMI pixel pack/unpack paths.
// Holds the default configuration, lane and keep widths, and the packed
// FIFO entry layout {data, x, y, keep, sof}, with sof in bit 0.
package display_hdmi_data_pack_pkg;

  localparam int DEF_PIXEL_BIT  = 32;
  localparam int DEF_PACK_BIT   = 64;
  localparam int DEF_FIFO_WIDTH = 10;
  localparam int DEF_OUT_DEPTH  = 4;

  localparam int PACK_DIV = DEF_PACK_BIT / DEF_PIXEL_BIT;
  localparam int KEEP_W   = 4;

  // Entry field offsets; x and data offsets depend on the coordinate width
  localparam int SOF_LSB  = 0;
  localparam int KEEP_LSB = SOF_LSB + 1;
  localparam int Y_LSB    = KEEP_LSB + KEEP_W;

  function automatic int x_lsb(input int fifo_width);
    return Y_LSB + fifo_width;
  endfunction

  function automatic int data_lsb(input int fifo_width);
    return Y_LSB + 2 * fifo_width;
  endfunction

  function automatic int entry_w(input int pack_bit, input int fifo_width);
    return pack_bit + 2 * fifo_width + KEEP_W + 1;
  endfunction

  localparam int ENTRY_W = entry_w(DEF_PACK_BIT, DEF_FIFO_WIDTH);

endpackage

// File: rtl/display_hdmi_pack_fifo.sv
// Single-clock first-word-fall-through FIFO for packed video words.
// Ports: in_pclk/in_rst (sync, active-high), wr_en/wr_data push side,
// rd_en/rd_data pop side (rd_data is the head, zero while empty),
// full/empty status. A write while full succeeds only with a same-cycle pop.
module display_hdmi_pack_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  in_pclk,
  input  logic                  in_rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  // Extra pointer bit distinguishes full from empty
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge in_pclk) begin
    if (in_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge in_pclk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/display_hdmi_data_pack.sv
// Packs a one-pixel-per-clock stream into PACK_BIT words (first pixel in the
// LSB lane) and queues them with word index, line index, keep and
// start-of-frame tags.
// Ports: in_pclk/in_rst (sync, active-high); in_valid/in_de/in_hs/in_vs/in_data
// pixel input (in_hs is status only); out_valid/out_ready/out_data/out_x/
// out_y/out_keep/out_sof packed word stream; out_line_done pulse per line;
// out_overflow sticky drop flag, cleared on frame start.
module display_hdmi_data_pack
  import display_hdmi_data_pack_pkg::*;
#(
  parameter int PIXEL_BIT  = DEF_PIXEL_BIT,
  parameter int PACK_BIT   = DEF_PACK_BIT,
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int OUT_DEPTH  = DEF_OUT_DEPTH
) (
  input  logic                  in_pclk,
  input  logic                  in_rst,
  input  logic                  in_valid,
  input  logic                  in_de,
  input  logic                  in_hs,
  input  logic                  in_vs,
  input  logic [PIXEL_BIT-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PACK_BIT-1:0]   out_data,
  output logic [FIFO_WIDTH-1:0] out_x,
  output logic [FIFO_WIDTH-1:0] out_y,
  output logic [KEEP_W-1:0]     out_keep,
  output logic                  out_sof,
  output logic                  out_line_done,
  output logic                  out_overflow
);

  localparam int LANES  = PACK_BIT / PIXEL_BIT;
  localparam int PCNT_W = $clog2(LANES);
  localparam int EW     = entry_w(PACK_BIT, FIFO_WIDTH);
  localparam int X_LSB  = x_lsb(FIFO_WIDTH);
  localparam int D_LSB  = data_lsb(FIFO_WIDTH);
  localparam logic [PCNT_W-1:0] LAST_LANE = PCNT_W'(LANES - 1);

  if (!(LANES == 2 || LANES == 4 || LANES == 8) || (LANES * PIXEL_BIT != PACK_BIT)) begin : g_bad_cfg
    $error("display_hdmi_data_pack: PACK_BIT/PIXEL_BIT must be 2, 4 or 8");
  end

  logic                  unused_hs;
  logic                  r_de_1P;
  logic                  r_vs_1P;
  logic                  r_skip;
  logic                  r_sof_pend;
  logic                  r_has_word;
  logic [PCNT_W-1:0]     r_pcnt;
  logic [PACK_BIT-1:0]   r_asm;
  logic [FIFO_WIDTH-1:0] r_wx;
  logic [FIFO_WIDTH-1:0] r_line;

  logic                  push_v;
  logic [PACK_BIT-1:0]   push_data;
  logic [FIFO_WIDTH-1:0] push_x;
  logic [FIFO_WIDTH-1:0] push_y;
  logic [KEEP_W-1:0]     push_keep;
  logic                  push_sof;

  logic                  line_end;
  logic                  frame_start;
  logic                  vs_fall;
  logic                  accept;
  logic                  complete;
  logic                  flush;
  logic                  push_now;
  logic                  pop;
  logic                  drop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [EW-1:0]         head;
  logic [PCNT_W-1:0]     lane;
  logic [PACK_BIT-1:0]   nxt_asm;

  assign unused_hs = in_hs;

  // r_skip ignores the remainder of a line that was active across reset
  assign line_end    = ~in_de & r_de_1P & ~r_skip;
  assign frame_start = in_vs & ~r_vs_1P;
  assign vs_fall     = ~in_vs & r_vs_1P;
  assign accept      = in_valid & in_de & ~r_skip;
  assign complete    = accept && (r_pcnt == LAST_LANE);
  // A vsync drop mid-line flushes the partial word with the old line index
  assign flush       = (line_end | vs_fall) && (r_pcnt != '0) && !complete;
  assign push_now    = complete | flush;

  // A pixel arriving alongside a flush starts the next word in lane 0
  always_comb begin
    lane    = flush ? '0 : r_pcnt;
    nxt_asm = flush ? '0 : r_asm;
    for (int i = 0; i < LANES; i++) begin
      if (accept && (PCNT_W'(i) == lane)) nxt_asm[i*PIXEL_BIT +: PIXEL_BIT] = in_data;
    end
  end

  assign pop  = out_valid & out_ready;
  assign drop = push_v & fifo_full & ~pop;

  always_ff @(posedge in_pclk) begin
    if (in_rst) begin
      r_de_1P       <= 1'b0;
      r_vs_1P       <= 1'b0;
      r_skip        <= 1'b1;
      r_sof_pend    <= 1'b1;
      r_has_word    <= 1'b0;
      r_pcnt        <= '0;
      r_asm         <= '0;
      r_wx          <= '0;
      r_line        <= '0;
      push_v        <= 1'b0;
      push_data     <= '0;
      push_x        <= '0;
      push_y        <= '0;
      push_keep     <= '0;
      push_sof      <= 1'b0;
      out_line_done <= 1'b0;
      out_overflow  <= 1'b0;
    end else begin
      r_de_1P       <= in_de;
      r_vs_1P       <= in_vs;
      out_line_done <= line_end;
      push_v        <= push_now;
      if (~in_de) r_skip <= 1'b0;

      if (push_now) begin
        push_data <= complete ? nxt_asm : r_asm;
        push_keep <= complete ? KEEP_W'(LANES) : KEEP_W'(r_pcnt);
        push_x    <= r_wx;
        push_y    <= r_line;
        push_sof  <= r_sof_pend;
      end

      if (complete) begin
        r_asm  <= '0;
        r_pcnt <= '0;
      end else if (accept) begin
        r_asm  <= nxt_asm;
        r_pcnt <= lane + 1'b1;
      end else if (flush) begin
        r_asm  <= '0;
        r_pcnt <= '0;
      end

      if (line_end) begin
        r_wx       <= '0;
        r_has_word <= 1'b0;
        if (r_has_word || push_now) r_line <= r_line + 1'b1;
      end else if (push_now) begin
        r_wx       <= r_wx + 1'b1;
        r_has_word <= 1'b1;
      end

      if (~in_vs) begin
        r_line     <= '0;
        r_sof_pend <= 1'b1;
      end else if (push_now) begin
        r_sof_pend <= 1'b0;
      end

      if (drop)             out_overflow <= 1'b1;
      else if (frame_start) out_overflow <= 1'b0;
    end
  end

  display_hdmi_pack_fifo #(
    .DATA_WIDTH(EW),
    .DEPTH     (OUT_DEPTH)
  ) u_fifo (
    .in_pclk(in_pclk),
    .in_rst (in_rst),
    .wr_en  (push_v),
    .wr_data({push_data, push_x, push_y, push_keep, push_sof}),
    .rd_en  (pop),
    .rd_data(head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_sof   = head[SOF_LSB];
  assign out_keep  = head[KEEP_LSB +: KEEP_W];
  assign out_y     = head[Y_LSB +: FIFO_WIDTH];
  assign out_x     = head[X_LSB +: FIFO_WIDTH];
  assign out_data  = head[D_LSB +: PACK_BIT];

endmodule

// File: tb/tb_display_hdmi_data_pack.sv
// Directed bench for display_hdmi_data_pack in the 32/64, depth-4 setup.
module tb_display_hdmi_data_pack;

  typedef struct packed {
    logic [63:0] d;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [3:0]  k;
    logic        s;
  } word_t;

  logic        in_pclk = 1'b0;
  logic        in_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_de = 1'b0;
  logic        in_hs = 1'b0;
  logic        in_vs = 1'b1;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [9:0]  out_x;
  logic [9:0]  out_y;
  logic [3:0]  out_keep;
  logic        out_sof;
  logic        out_line_done;
  logic        out_overflow;

  int    n_tests = 0;
  int    n_fail = 0;
  int    ld_cnt = 0;
  word_t q[$];
  word_t exp_w[$];

  display_hdmi_data_pack dut (
    .in_pclk      (in_pclk),
    .in_rst       (in_rst),
    .in_valid     (in_valid),
    .in_de        (in_de),
    .in_hs        (in_hs),
    .in_vs        (in_vs),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_x        (out_x),
    .out_y        (out_y),
    .out_keep     (out_keep),
    .out_sof      (out_sof),
    .out_line_done(out_line_done),
    .out_overflow (out_overflow)
  );

  always #5 in_pclk = ~in_pclk;

  // Inputs change just after posedge, so the negedge sees settled pop decisions
  always @(negedge in_pclk) begin
    if (out_valid && out_ready) q.push_back({out_data, out_x, out_y, out_keep, out_sof});
    if (out_line_done) ld_cnt++;
  end

  function automatic word_t mk(input logic [31:0] hi, input logic [31:0] lo,
                               input int x, input int y, input int k, input bit s);
    word_t w;
    w.d = {hi, lo};
    w.x = 10'(x);
    w.y = 10'(y);
    w.k = 4'(k);
    w.s = s;
    return w;
  endfunction

  task automatic drive(input logic v, input logic de, input logic vs, input logic [31:0] d);
    in_valid = v;
    in_de    = de;
    in_vs    = vs;
    in_data  = d;
    @(posedge in_pclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic pixel_line(input int n, input int stride, input logic [31:0] first);
    for (int i = 0; i < n; i++) begin
      for (int g = 1; g < stride; g++) drive(1'b0, 1'b1, 1'b1, 32'h0);
      drive(1'b1, 1'b1, 1'b1, first + 32'(i));
    end
    idle(8);
  endtask

  task automatic test_reset;
    in_rst = 1'b1;
    idle(3);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_tests++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL reset out_data: got %h want 0", out_data); end
    n_tests++; if (out_x !== 10'h0) begin n_fail++; $display("FAIL reset out_x: got %h want 0", out_x); end
    n_tests++; if (out_y !== 10'h0) begin n_fail++; $display("FAIL reset out_y: got %h want 0", out_y); end
    n_tests++; if (out_keep !== 4'h0) begin n_fail++; $display("FAIL reset out_keep: got %h want 0", out_keep); end
    n_tests++; if (out_sof !== 1'b0) begin n_fail++; $display("FAIL reset out_sof: got %b want 0", out_sof); end
    n_tests++; if (out_line_done !== 1'b0) begin n_fail++; $display("FAIL reset out_line_done: got %b want 0", out_line_done); end
    n_tests++; if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL reset out_overflow: got %b want 0", out_overflow); end
    in_rst = 1'b0;
    idle(2);
  endtask

  task automatic test_full_line;
    q.delete(); exp_w.delete(); ld_cnt = 0;
    pixel_line(8, 1, 32'h1);
    for (int i = 0; i < 4; i++) exp_w.push_back(mk(32'(2*i+2), 32'(2*i+1), i, 0, 2, i == 0));
    n_tests++; if (q.size() != exp_w.size()) begin n_fail++; $display("FAIL full_line count: got %0d want %0d", q.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size(); i++) begin
      n_tests++;
      if (i >= q.size() || q[i] !== exp_w[i]) begin
        n_fail++; $display("FAIL full_line word %0d: got %h want %h", i, (i < q.size()) ? q[i] : '0, exp_w[i]);
      end
    end
    n_tests++; if (ld_cnt != 1) begin n_fail++; $display("FAIL full_line line_done pulses: got %0d want 1", ld_cnt); end
  endtask

  task automatic test_odd_line;
    q.delete(); exp_w.delete(); ld_cnt = 0;
    pixel_line(5, 1, 32'h1);
    pixel_line(2, 1, 32'h11);
    exp_w.push_back(mk(32'h2, 32'h1, 0, 1, 2, 1'b0));
    exp_w.push_back(mk(32'h4, 32'h3, 1, 1, 2, 1'b0));
    exp_w.push_back(mk(32'h0, 32'h5, 2, 1, 1, 1'b0));
    exp_w.push_back(mk(32'h12, 32'h11, 0, 2, 2, 1'b0));
    n_tests++; if (q.size() != exp_w.size()) begin n_fail++; $display("FAIL odd_line count: got %0d want %0d", q.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size(); i++) begin
      n_tests++;
      if (i >= q.size() || q[i] !== exp_w[i]) begin
        n_fail++; $display("FAIL odd_line word %0d: got %h want %h", i, (i < q.size()) ? q[i] : '0, exp_w[i]);
      end
    end
    n_tests++; if (ld_cnt != 2) begin n_fail++; $display("FAIL odd_line line_done pulses: got %0d want 2", ld_cnt); end
  endtask

  task automatic test_latency;
    q.delete(); ld_cnt = 0;
    drive(1'b1, 1'b1, 1'b1, 32'hA);
    drive(1'b1, 1'b1, 1'b1, 32'hB);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency early out_valid: got %b want 0", out_valid); end
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency out_valid: got %b want 1", out_valid); end
    n_tests++; if (out_data !== 64'h0000000B_0000000A) begin n_fail++; $display("FAIL latency out_data: got %h want 0000000b0000000a", out_data); end
    n_tests++; if (out_line_done !== 1'b1) begin n_fail++; $display("FAIL latency out_line_done: got %b want 1", out_line_done); end
    idle(6);
    n_tests++;
    if (q.size() != 1 || q[0] !== mk(32'hB, 32'hA, 0, 3, 2, 1'b0)) begin
      n_fail++; $display("FAIL latency word: got %h (count %0d) want %h", (q.size() > 0) ? q[0] : '0, q.size(), mk(32'hB, 32'hA, 0, 3, 2, 1'b0));
    end
    n_tests++; if (ld_cnt != 1) begin n_fail++; $display("FAIL latency line_done pulses: got %0d want 1", ld_cnt); end
  endtask

  task automatic test_gaps;
    q.delete(); exp_w.delete(); ld_cnt = 0;
    pixel_line(8, 3, 32'h1);
    for (int i = 0; i < 4; i++) exp_w.push_back(mk(32'(2*i+2), 32'(2*i+1), i, 4, 2, 1'b0));
    n_tests++; if (q.size() != exp_w.size()) begin n_fail++; $display("FAIL gaps count: got %0d want %0d", q.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size(); i++) begin
      n_tests++;
      if (i >= q.size() || q[i] !== exp_w[i]) begin
        n_fail++; $display("FAIL gaps word %0d: got %h want %h", i, (i < q.size()) ? q[i] : '0, exp_w[i]);
      end
    end
  endtask

  task automatic test_empty_line;
    q.delete(); ld_cnt = 0;
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, 32'h0);
    idle(4);
    n_tests++; if (q.size() != 0) begin n_fail++; $display("FAIL empty_line count: got %0d want 0", q.size()); end
    n_tests++; if (ld_cnt != 1) begin n_fail++; $display("FAIL empty_line line_done pulses: got %0d want 1", ld_cnt); end
    pixel_line(2, 1, 32'h41);
    n_tests++;
    if (q.size() != 1 || q[0] !== mk(32'h42, 32'h41, 0, 5, 2, 1'b0)) begin
      n_fail++; $display("FAIL empty_line next y: got %h (count %0d) want %h", (q.size() > 0) ? q[0] : '0, q.size(), mk(32'h42, 32'h41, 0, 5, 2, 1'b0));
    end
  endtask

  task automatic test_vertical;
    q.delete(); exp_w.delete();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 32'h0);
    idle(2);
    pixel_line(4, 1, 32'h51);
    exp_w.push_back(mk(32'h52, 32'h51, 0, 0, 2, 1'b1));
    exp_w.push_back(mk(32'h54, 32'h53, 1, 0, 2, 1'b0));
    n_tests++; if (q.size() != exp_w.size()) begin n_fail++; $display("FAIL vertical count: got %0d want %0d", q.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size(); i++) begin
      n_tests++;
      if (i >= q.size() || q[i] !== exp_w[i]) begin
        n_fail++; $display("FAIL vertical word %0d: got %h want %h", i, (i < q.size()) ? q[i] : '0, exp_w[i]);
      end
    end
  endtask

  task automatic test_overflow;
    word_t head_exp;
    q.delete(); exp_w.delete();
    head_exp = mk(32'h2, 32'h1, 0, 1, 2, 1'b0);
    out_ready = 1'b0;
    pixel_line(12, 1, 32'h1);
    n_tests++; if (out_overflow !== 1'b1) begin n_fail++; $display("FAIL overflow flag set: got %b want 1", out_overflow); end
    n_tests++;
    if ({out_data, out_x, out_y, out_keep, out_sof} !== head_exp) begin
      n_fail++; $display("FAIL overflow head: got %h want %h", {out_data, out_x, out_y, out_keep, out_sof}, head_exp);
    end
    idle(3);
    n_tests++;
    if (out_valid !== 1'b1 || {out_data, out_x, out_y, out_keep, out_sof} !== head_exp) begin
      n_fail++; $display("FAIL overflow head held: got %h valid %b want %h", {out_data, out_x, out_y, out_keep, out_sof}, out_valid, head_exp);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    n_tests++; if (out_overflow !== 1'b1) begin n_fail++; $display("FAIL overflow sticky in vblank: got %b want 1", out_overflow); end
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    n_tests++; if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL overflow clear on vs rise: got %b want 0", out_overflow); end
    out_ready = 1'b1;
    idle(8);
    for (int i = 0; i < 4; i++) exp_w.push_back(mk(32'(2*i+2), 32'(2*i+1), i, 1, 2, 1'b0));
    n_tests++; if (q.size() != exp_w.size()) begin n_fail++; $display("FAIL overflow kept count: got %0d want %0d", q.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size(); i++) begin
      n_tests++;
      if (i >= q.size() || q[i] !== exp_w[i]) begin
        n_fail++; $display("FAIL overflow word %0d: got %h want %h", i, (i < q.size()) ? q[i] : '0, exp_w[i]);
      end
    end
  endtask

  task automatic test_reset_mid_line;
    exp_w.delete();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 32'h31 + 32'(i));
    in_rst = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 32'h0);
    n_tests++;
    if ({out_valid, out_data, out_x, out_y, out_keep, out_sof, out_line_done, out_overflow} !== '0) begin
      n_fail++; $display("FAIL reset_mid outputs: got valid %b data %h x %h y %h keep %h sof %b ld %b ovf %b want all 0",
                         out_valid, out_data, out_x, out_y, out_keep, out_sof, out_line_done, out_overflow);
    end
    in_rst = 1'b0;
    q.delete(); ld_cnt = 0;
    drive(1'b1, 1'b1, 1'b1, 32'h99);
    idle(4);
    pixel_line(4, 1, 32'h21);
    exp_w.push_back(mk(32'h22, 32'h21, 0, 0, 2, 1'b1));
    exp_w.push_back(mk(32'h24, 32'h23, 1, 0, 2, 1'b0));
    n_tests++; if (q.size() != exp_w.size()) begin n_fail++; $display("FAIL reset_mid count: got %0d want %0d", q.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size(); i++) begin
      n_tests++;
      if (i >= q.size() || q[i] !== exp_w[i]) begin
        n_fail++; $display("FAIL reset_mid word %0d: got %h want %h", i, (i < q.size()) ? q[i] : '0, exp_w[i]);
      end
    end
    n_tests++; if (ld_cnt != 1) begin n_fail++; $display("FAIL reset_mid line_done pulses: got %0d want 1", ld_cnt); end
  endtask

  initial begin
    #1;
    test_reset();
    test_full_line();
    test_odd_line();
    test_latency();
    test_gaps();
    test_empty_line();
    test_vertical();
    test_overflow();
    test_reset_mid_line();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
